hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W). Keeps a shadow copy of destination-register and writeback-control fields per stage, driving forwarding selects for the E-stage ALU operand muxes and stall/flush strobes for pipeline registers. Sits beside the datapath, fed by decode-stage outputs and E-stage branch resolution (pcSrcE = branchE & zeroE). Also freezes the whole pipe on a data-memory wait.

Parameters:
REG_ADDR_W, 5, register index width
PERF_CNT_W, 32, performance counter width (optional feature only)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
rs1D  input  REG_ADDR_W  D-stage source 1 index
rs2D  input  REG_ADDR_W  D-stage source 2 index
rdD  input  REG_ADDR_W  D-stage destination index
regWriteD  input  1  D-stage instruction writes rd
resultSrcD  input  1  D-stage instruction is a load (result from memory)
pcSrcE  input  1  E-stage taken branch/jump
memStallM  input  1  data memory not ready; freeze pipeline
forwardAE  output  2  00 regfile, 10 from M ALU result, 01 from W result
forwardBE  output  2  same encoding for operand B
stallF  output  1  hold PC
stallD  output  1  hold IF/ID register
stallE  output  1  hold ID/EX register
stallM  output  1  hold EX/MEM and MEM/WB registers
flushD  output  1  clear IF/ID register
flushE  output  1  clear ID/EX register (insert bubble)

Behaviour:
- Shadow state: E {rs1E, rs2E, rdE, regWriteE, resultSrcE}, M {rdM, regWriteM}, W {rdW, regWriteW}.
- rst high at a clock edge: all shadow fields become 0.
- While rst is high: stall* = 0, flushD = flushE = 1, forward* = 00.
- Update on each edge when not in reset:
  - memStallM = 1: all shadow state holds.
  - Otherwise, W <= M and M <= E.
  - E <= D inputs, or all-zero bubble if flushE is high.
- lwStall = regWriteE & resultSrcE & (rdE != 0) & ((rdE == rs1D) | (rdE == rs2D)).
- Outputs are combinational from shadow state and inputs. Priority is highest first:
  1. memStallM: stallF = stallD = stallE = stallM = 1; flushD = flushE = 0. A pending lwStall or pcSrcE is held, not acted on.
  2. pcSrcE: flushD = flushE = 1; stallF = stallD = 0 so the branch target is fetched. lwStall is ignored because the D instruction is on the wrong path.
  3. lwStall: stallF = stallD = 1 and flushE = 1. Resolves in exactly 1 cycle; the dependent then receives forwardXE = 01.
  4. None of the above: all stalls and flushes 0.
- Forwarding for operand A: 10 if regWriteM & rdM != 0 & rdM == rs1E; else 01 if regWriteW & rdW != 0 & rdW == rs1E; else 00. Operand B is identical using rs2E.
- M always beats W when both match. x0 is never forwarded.
- A bubble has regWrite = 0, so it never forwards or causes a stall.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stallCnt and flushCnt, both PERF_CNT_W wide.
  - stallCnt increments once per cycle in which lwStall is acted on.
  - flushCnt increments once per cycle with pcSrcE acted on.
  - Neither counts during memStallM. Both wrap at 2^PERF_CNT_W. Both clear on rst.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles, then drop with all inputs 0 → forward* = 00, stall* = 0, flushD = flushE = 0 on first non-reset cycle.
- EX→EX forward: issue add x5 (rdD = 5, regWriteD = 1), then sub using rs1 = 5 → when sub in E, forwardAE = 10; one cycle later a third instr with rs2 = 5 in E sees forwardBE = 01.
- Load-use: lw x7 followed by add rs1D = 7 → one cycle of stallF = stallD = flushE = 1. Next cycle all 0 and forwardAE = 01.
- x0 and bubble: lw x0 then use rs1 = 0 → no stall, forwardAE = 00.
- Branch vs load-use: pcSrcE = 1 in the same cycle lwStall would fire → flushD = flushE = 1, stallF = stallD = 0.
- Memory wait: memStallM = 1 for 3 cycles mid-stream with a pending M→E forward → all stalls 1 for 3 cycles, forwardAE stays 10, shadow unchanged. Then normal flow resumes.
- Reset mid-operation: with lwStall active, rst for 1 cycle → next cycle no stall, no forwarding.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage forwarding selects and stall/flush strobes; `define HAZ_PERF_CNT_EN adds stallCnt/flushCnt
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  regWriteD,
  input  logic                  resultSrcD,
  input  logic                  pcSrcE,
  input  logic                  memStallM,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  flushE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stallCnt,
  output logic [PERF_CNT_W-1:0] flushCnt
`endif
);
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_e, result_src_e, reg_write_m, reg_write_w;
  logic lw_stall, m_ok, w_ok, branch_act, load_act;
  always_ff @(posedge clk) begin
    if (rst) begin
      {rs1_e, rs2_e, rd_e, reg_write_e, result_src_e} <= '0;
      {rd_m, reg_write_m, rd_w, reg_write_w} <= '0;
    end else if (!memStallM) begin
      rd_w         <= rd_m;
      reg_write_w  <= reg_write_m;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      rs1_e        <= flushE ? '0 : rs1D;
      rs2_e        <= flushE ? '0 : rs2D;
      rd_e         <= flushE ? '0 : rdD;
      reg_write_e  <= !flushE && regWriteD;
      result_src_e <= !flushE && resultSrcD;
    end
  end
  always_comb begin
    lw_stall   = reg_write_e && result_src_e && rd_e != '0 && (rd_e == rs1D || rd_e == rs2D);
    branch_act = !rst && !memStallM && pcSrcE;
    load_act   = !rst && !memStallM && !pcSrcE && lw_stall;
    m_ok       = reg_write_m && rd_m != '0;
    w_ok       = reg_write_w && rd_w != '0;
    forwardAE  = rst ? 2'b00 : (m_ok && rd_m == rs1_e) ? 2'b10 : (w_ok && rd_w == rs1_e) ? 2'b01 : 2'b00;
    forwardBE  = rst ? 2'b00 : (m_ok && rd_m == rs2_e) ? 2'b10 : (w_ok && rd_w == rs2_e) ? 2'b01 : 2'b00;
    stallE     = !rst && memStallM;
    stallM     = stallE;
    stallF     = stallE || load_act;
    stallD     = stallF;
    flushD     = rst || branch_act;
    flushE     = rst || branch_act || load_act;
  end
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      stallCnt <= stallCnt + PERF_CNT_W'(load_act);
      flushCnt <= flushCnt + PERF_CNT_W'(branch_act);
    end
  end
`endif
endmodule
